// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - channel indices and debounce defaults shared with the controller top
package input_conditioner_pkg;

    localparam int N_CH_DEF       = 3;
    localparam int DEB_CYCLES_DEF = 16;

    localparam int CH_ASP = 0;
    localparam int CH_GOT = 1;
    localparam int CH_ADB = 2;

endpackage

// File: rtl/input_conditioner_if.sv
// rtl/input_conditioner_if.sv - raw switch inputs and conditioned level/edge outputs
interface input_conditioner_if #(
    parameter int N_CH = 3
);
    logic [N_CH-1:0] raw_in;
    logic [N_CH-1:0] clean;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic            busy;

    modport master (
        output raw_in,
        input  clean, rise, fall, busy
    );

    modport slave (
        input  raw_in,
        output clean, rise, fall, busy
    );
endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one-bit 2-flop synchronizer, debounce counter and edge pulses
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter bit INVERT     = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic settling
);
    localparam int CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Polarity is applied after the synchronizer so an idle-high active-low input settles at 0.
    assign level = s2 ^ INVERT;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (level == clean) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                clean <= level;
                rise  <= level;
                fall  <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign settling = (cnt != '0);

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounced switch front end; INPUT_INVERT_EN selects active-low raw inputs
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int N_CH       = N_CH_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input_conditioner_if.slave bus
);
`ifdef INPUT_INVERT_EN
    localparam bit INVERT = 1'b1;
`else
    localparam bit INVERT = 1'b0;
`endif

    logic [N_CH-1:0] clean_v;
    logic [N_CH-1:0] rise_v;
    logic [N_CH-1:0] fall_v;
    logic [N_CH-1:0] settling;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        debounce_channel #(
            .DEB_CYCLES (DEB_CYCLES),
            .INVERT     (INVERT)
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .raw      (bus.raw_in[gi]),
            .clean    (clean_v[gi]),
            .rise     (rise_v[gi]),
            .fall     (fall_v[gi]),
            .settling (settling[gi])
        );
    end

    assign bus.clean = clean_v;
    assign bus.rise  = rise_v;
    assign bus.fall  = fall_v;
    assign bus.busy  = |settling;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
module tb_input_conditioner;

`ifdef INPUT_INVERT_EN
    localparam logic [2:0] IDLE = 3'b111;
`else
    localparam logic [2:0] IDLE = 3'b000;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    input_conditioner_if #(.N_CH(3)) bus ();

    input_conditioner #(
        .N_CH       (3),
        .DEB_CYCLES (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.raw_in = 3'b001;
        step();
        step();
        checks++;
        if (bus.clean !== 3'b000) begin errors++; $display("FAIL reset_clean: got %b expected 000", bus.clean); end
        checks++;
        if (bus.rise !== 3'b000) begin errors++; $display("FAIL reset_rise: got %b expected 000", bus.rise); end
        checks++;
        if (bus.fall !== 3'b000) begin errors++; $display("FAIL reset_fall: got %b expected 000", bus.fall); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_startup();
        logic [2:0] exp_c, exp_r;
        logic       exp_b;
        reset = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            step();
            exp_c = (i >= 18) ? 3'b001 : 3'b000;
            exp_r = (i == 18) ? 3'b001 : 3'b000;
            exp_b = (i >= 3 && i <= 17);
            checks++;
            if (bus.clean !== exp_c) begin errors++; $display("FAIL startup_clean edge %0d: got %b expected %b", i, bus.clean, exp_c); end
            checks++;
            if (bus.rise !== exp_r) begin errors++; $display("FAIL startup_rise edge %0d: got %b expected %b", i, bus.rise, exp_r); end
            checks++;
            if (bus.fall !== 3'b000) begin errors++; $display("FAIL startup_fall edge %0d: got %b expected 000", i, bus.fall); end
            checks++;
            if (bus.busy !== exp_b) begin errors++; $display("FAIL startup_busy edge %0d: got %b expected %b", i, bus.busy, exp_b); end
        end
    endtask

    task automatic test_glitch();
        logic exp_b;
        bus.raw_in = 3'b011;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i == 10) bus.raw_in = 3'b001;
            exp_b = (i >= 3 && i <= 12);
            checks++;
            if (bus.clean !== 3'b001) begin errors++; $display("FAIL glitch_clean edge %0d: got %b expected 001", i, bus.clean); end
            checks++;
            if ((bus.rise | bus.fall) !== 3'b000) begin errors++; $display("FAIL glitch_pulse edge %0d: got rise %b fall %b expected none", i, bus.rise, bus.fall); end
            checks++;
            if (bus.busy !== exp_b) begin errors++; $display("FAIL glitch_busy edge %0d: got %b expected %b", i, bus.busy, exp_b); end
        end
    endtask

    task automatic test_bounce();
        int         n_rise;
        logic [2:0] exp_c;
        for (int k = 0; k < 5; k++) begin
            for (int h = 0; h < 6; h++) begin
                bus.raw_in = (h < 3) ? 3'b101 : 3'b001;
                step();
                checks++;
                if (bus.clean !== 3'b001 || bus.rise !== 3'b000) begin
                    errors++;
                    $display("FAIL bounce_hold k %0d h %0d: got clean %b rise %b expected 001/000", k, h, bus.clean, bus.rise);
                end
            end
        end
        bus.raw_in = 3'b101;
        n_rise = 0;
        for (int i = 1; i <= 24; i++) begin
            step();
            if (bus.rise[2]) n_rise++;
            exp_c = (i >= 18) ? 3'b101 : 3'b001;
            checks++;
            if (bus.clean !== exp_c) begin errors++; $display("FAIL bounce_clean edge %0d: got %b expected %b", i, bus.clean, exp_c); end
            checks++;
            if (bus.fall !== 3'b000) begin errors++; $display("FAIL bounce_fall edge %0d: got %b expected 000", i, bus.fall); end
        end
        checks++;
        if (n_rise != 1) begin errors++; $display("FAIL bounce_rise_count: got %0d expected 1", n_rise); end
    endtask

    task automatic test_simultaneous();
        logic [2:0] exp_c, exp_f;
        bus.raw_in = 3'b111;
        for (int i = 1; i <= 18; i++) step();
        checks++;
        if (bus.clean !== 3'b111) begin errors++; $display("FAIL simul_setup: got %b expected 111", bus.clean); end
        bus.raw_in = 3'b000;
        for (int i = 1; i <= 19; i++) begin
            step();
            exp_c = (i >= 18) ? 3'b000 : 3'b111;
            exp_f = (i == 18) ? 3'b111 : 3'b000;
            checks++;
            if (bus.clean !== exp_c) begin errors++; $display("FAIL simul_clean edge %0d: got %b expected %b", i, bus.clean, exp_c); end
            checks++;
            if (bus.fall !== exp_f) begin errors++; $display("FAIL simul_fall edge %0d: got %b expected %b", i, bus.fall, exp_f); end
            checks++;
            if (bus.rise !== 3'b000) begin errors++; $display("FAIL simul_rise edge %0d: got %b expected 000", i, bus.rise); end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp_c, exp_r;
        bus.raw_in = 3'b111;
        for (int i = 1; i <= 14; i++) step();
        checks++;
        if (bus.busy !== 1'b1 || bus.clean !== 3'b000) begin
            errors++;
            $display("FAIL midreset_pre: got busy %b clean %b expected 1/000", bus.busy, bus.clean);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.clean, bus.rise, bus.fall, bus.busy} !== 10'b0) begin
            errors++;
            $display("FAIL midreset_clear: got clean %b rise %b fall %b busy %b expected all 0", bus.clean, bus.rise, bus.fall, bus.busy);
        end
        step();
        step();
        reset = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            step();
            exp_c = (i >= 18) ? 3'b111 : 3'b000;
            exp_r = (i == 18) ? 3'b111 : 3'b000;
            checks++;
            if (bus.clean !== exp_c) begin errors++; $display("FAIL midreset_clean edge %0d: got %b expected %b", i, bus.clean, exp_c); end
            checks++;
            if (bus.rise !== exp_r) begin errors++; $display("FAIL midreset_rise edge %0d: got %b expected %b", i, bus.rise, exp_r); end
        end
    endtask

    task automatic test_polarity();
        logic [2:0] exp_c, exp_r;
        reset = 1'b0;
        bus.raw_in = IDLE;
        step();
        step();
        reset = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            step();
            checks++;
            if (bus.clean !== 3'b000 || bus.rise !== 3'b000) begin
                errors++;
                $display("FAIL polarity_idle edge %0d: got clean %b rise %b expected 000/000", i, bus.clean, bus.rise);
            end
        end
        bus.raw_in = IDLE ^ 3'b001;
        for (int i = 1; i <= 19; i++) begin
            step();
            exp_c = (i >= 18) ? 3'b001 : 3'b000;
            exp_r = (i == 18) ? 3'b001 : 3'b000;
            checks++;
            if (bus.clean !== exp_c) begin errors++; $display("FAIL polarity_clean edge %0d: got %b expected %b", i, bus.clean, exp_c); end
            checks++;
            if (bus.rise !== exp_r) begin errors++; $display("FAIL polarity_rise edge %0d: got %b expected %b", i, bus.rise, exp_r); end
        end
    endtask

    initial begin
        bus.raw_in = 3'b000;
        test_reset();
        test_startup();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_polarity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
